bcd_to_binary_seq: RTL and testbench

- Sequential packed-BCD to binary converter, the inverse of the scale's binary-to-BCD display path.
- Used where the operator keypad or tare entry supplies decimal digits that must become a binary weight value for arithmetic.
- Implements reverse double-dabble: one right-shift per clock, with a subtract-3 correction on every BCD digit >= 8.
- START/BUSY/DONE handshake, same style as the existing converter.

---
 rtl/bcd_to_binary_seq.sv | 167 ++++++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// Each clock shifts the {bcd, acc} pair right by one bit. Every BCD digit that
// lands at 8 or above is then corrected by subtracting 3. After 4*DIGITS shifts
// the accumulator holds the binary value.
// Optional macro BCD_CHECK_EN: rejects any digit > 9 on START, setting ERR and
// BINOUT=0 with a one-cycle latency. When the macro is absent, ERR is tied to 0.
module bcd_to_binary_seq #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [4*DIGITS-1:0]   BCDIN,
  output logic [BIN_W-1:0]      BINOUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int unsigned N  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned XW = (BIN_W > N) ? BIN_W : N;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      bcd_q, bcd_d;
  logic [N-1:0]      acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BIN_W-1:0]  binout_q, binout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [N-1:0]      bcd_sh;
  logic [N-1:0]      bcd_corr;
  logic [N-1:0]      acc_sh;
  logic [XW-1:0]     acc_ext;

`ifdef BCD_CHECK_EN
  logic              err_q, err_d;
  logic              bad_digit;

  // Flag any input digit outside 0..9
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (BCDIN[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end
`endif

  // One datapath step: shift right, then correct each digit that reached >= 8
  always_comb begin
    bcd_sh   = bcd_q >> 1;
    acc_sh   = {bcd_q[0], acc_q[N-1:1]};
    bcd_corr = bcd_sh;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_sh[4*i +: 4] >= 4'd8) bcd_corr[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
    end
  end

  assign acc_ext = XW'(acc_sh);

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    binout_d = binout_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef BCD_CHECK_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
`ifdef BCD_CHECK_EN
          if (bad_digit) begin
            state_d  = S_DONE;
            binout_d = '0;
            err_d    = 1'b1;
            busy_d   = 1'b1;
            done_d   = 1'b1;
          end else begin
            state_d = S_SHIFT;
            bcd_d   = BCDIN;
            acc_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
`else
          state_d = S_SHIFT;
          bcd_d   = BCDIN;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
`endif
        end
      end
      S_SHIFT: begin
        busy_d = 1'b1;
        bcd_d  = bcd_corr;
        acc_d  = acc_sh;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d  = S_DONE;
          binout_d = acc_ext[BIN_W-1:0];
          done_d   = 1'b1;
`ifdef BCD_CHECK_EN
          err_d    = 1'b0;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      bcd_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      binout_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      binout_q <= binout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef BCD_CHECK_EN
  // Error flag register, updated together with BINOUT
  always_ff @(posedge CLK) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign BINOUT = binout_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Testbench for bcd_to_binary_seq. Expected values come from a decimal model
// (sum of digit * 10^i). They are queued at START and popped when DONE fires.
module tb_bcd_to_binary_seq;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned BIN_W  = 16;
  localparam int          N      = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [15:0] BCDIN;
  logic [15:0] BINOUT;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .BCDIN (BCDIN),
    .BINOUT(BINOUT),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .ERR   (ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [15:0] bcd_model(input logic [15:0] b);
    int v;
    int p;
    v = 0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      v = v + int'(b[4*i +: 4]) * p;
      p = p * 10;
    end
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full conversion with latency, result and handshake checks
  task automatic run_conv(input logic [15:0] bcd, input string tag);
    int          cyc;
    logic [15:0] exp;
    exp_q.push_back(bcd_model(bcd));
    BCDIN = bcd;
    START = 1'b1;
    tick();
    START = 1'b0;
    n_checks++;
    if (BUSY !== 1'b1 || DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start_edge: BUSY=%b DONE=%b, required BUSY=1 DONE=0", tag, BUSY, DONE);
    end
    cyc = 0;
    while (DONE !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != N) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, required %0d", tag, cyc, N);
    end
    if (exp_q.size() == 0) exp = 16'hxxxx;
    else                   exp = exp_q.pop_front();
    n_checks++;
    if (BINOUT !== exp || ERR !== 1'b0 || BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s result: BINOUT=%h ERR=%b BUSY=%b, required BINOUT=%h ERR=0 BUSY=1",
               tag, BINOUT, ERR, BUSY, exp);
    end
    tick();
    n_checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: DONE=%b BUSY=%b, required 0 0", tag, DONE, BUSY);
    end
  endtask

  task automatic test_reset();
    RST   = 1'b1;
    START = 1'b1;
    BCDIN = 16'h9999;
    tick();
    tick();
    n_checks++;
    if (BINOUT !== 16'h0 || BUSY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: BINOUT=%h BUSY=%b DONE=%b ERR=%b, required all 0",
               BINOUT, BUSY, DONE, ERR);
    end
    RST   = 1'b0;
    START = 1'b0;
    tick();
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: BUSY=%b, required 0", BUSY);
    end
  endtask

  task automatic test_basic();
    run_conv(16'h0002, "conv_0002");
    run_conv(16'h9999, "conv_9999");
    run_conv(16'h1234, "conv_1234");
    tick();
    tick();
    n_checks++;
    if (BINOUT !== 16'h04D2) begin
      n_fail++;
      $display("FAIL hold_binout: BINOUT=%h, required 04d2", BINOUT);
    end
    run_conv(16'h0000, "conv_0000");
  endtask

  task automatic test_random();
    logic [15:0] b;
    for (int t = 0; t < 6; t++) begin
      for (int d = 0; d < 4; d++) b[4*d +: 4] = 4'($urandom_range(0, 9));
      run_conv(b, "conv_random");
    end
  endtask

  task automatic test_ignore_start();
    int          ndone;
    logic [15:0] exp;
    ndone = 0;
    exp_q.push_back(bcd_model(16'h1234));
    BCDIN = 16'h1234;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 3 || c == 10) begin
        START = 1'b1;
        BCDIN = 16'h5555;
      end else begin
        START = 1'b0;
      end
      if (DONE === 1'b1) begin
        ndone++;
        n_checks++;
        if (c != N) begin
          n_fail++;
          $display("FAIL ignore_latency: DONE at cycle %0d, required %0d", c, N);
        end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        n_checks++;
        if (BINOUT !== exp) begin
          n_fail++;
          $display("FAIL ignore_result: BINOUT=%h, required %h", BINOUT, exp);
        end
      end
    end
    n_checks++;
    if (ndone != 1) begin
      n_fail++;
      $display("FAIL ignore_done_count: %0d pulses, required 1", ndone);
    end
  endtask

  task automatic test_start_held();
    int          ndone;
    int          last;
    logic        prev_busy;
    logic [15:0] exp;
    ndone = 0;
    last  = 0;
    BCDIN = 16'h0042;
    START = 1'b1;
    prev_busy = BUSY;
    for (int c = 1; c <= 56; c++) begin
      tick();
      if (BUSY === 1'b1 && prev_busy === 1'b0) exp_q.push_back(bcd_model(16'h0042));
      if (DONE === 1'b1) begin
        ndone++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        n_checks++;
        if (BINOUT !== exp || BINOUT !== 16'h002A) begin
          n_fail++;
          $display("FAIL held_result: BINOUT=%h, required 002a", BINOUT);
        end
        if (last != 0) begin
          n_checks++;
          if (c - last != N + 2) begin
            n_fail++;
            $display("FAIL held_period: %0d cycles between DONE, required %0d", c - last, N + 2);
          end
        end
        last = c;
      end
      prev_busy = BUSY;
    end
    n_checks++;
    if (ndone != 3) begin
      n_fail++;
      $display("FAIL held_done_count: %0d pulses, required 3", ndone);
    end
    START = 1'b0;
    for (int c = 0; c < 40 && BUSY === 1'b1; c++) begin
      tick();
      if (DONE === 1'b1 && exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (BINOUT !== exp) begin
          n_fail++;
          $display("FAIL held_drain: BINOUT=%h, required %h", BINOUT, exp);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL held_idle: pending=%0d BUSY=%b, required 0 0", exp_q.size(), BUSY);
    end
  endtask

  task automatic test_reset_abort();
    int ndone;
    exp_q.push_back(bcd_model(16'h9999));
    BCDIN = 16'h9999;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp_q.delete();
    n_checks++;
    if (BINOUT !== 16'h0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: BINOUT=%h BUSY=%b DONE=%b, required 0 0 0", BINOUT, BUSY, DONE);
    end
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (DONE === 1'b1) ndone++;
    end
    n_checks++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: %0d pulses, required 0", ndone);
    end
    run_conv(16'h0100, "conv_after_abort");
  endtask

  task automatic test_digit_check();
    int cyc;
`ifdef BCD_CHECK_EN
    BCDIN = 16'h00A5;
    START = 1'b1;
    tick();
    START = 1'b0;
    n_checks++;
    if (DONE !== 1'b1 || ERR !== 1'b1 || BINOUT !== 16'h0 || BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL err_detect: DONE=%b ERR=%b BINOUT=%h BUSY=%b, required 1 1 0000 1",
               DONE, ERR, BINOUT, BUSY);
    end
    tick();
    n_checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || ERR !== 1'b1) begin
      n_fail++;
      $display("FAIL err_after: DONE=%b BUSY=%b ERR=%b, required 0 0 1", DONE, BUSY, ERR);
    end
`else
    BCDIN = 16'h00A5;
    START = 1'b1;
    tick();
    START = 1'b0;
    cyc = 0;
    while (DONE !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != N || ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL noerr_invalid: latency=%0d ERR=%b, required %0d 0", cyc, ERR, N);
    end
    tick();
`endif
    run_conv(16'h0010, "conv_after_invalid");
  endtask

  initial begin
    RST   = 1'b0;
    START = 1'b0;
    BCDIN = 16'h0;
    test_reset();
    test_basic();
    test_random();
    test_ignore_start();
    test_start_held();
    test_reset_abort();
    test_digit_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
